// File: rtl/rle_word_sched_if.sv
// Bundle of the RLE symbol input, output-SRAM port and entropy-coder read port
// for rle_word_sched. The slave modport is the scheduler; master is its environment.
interface rle_word_sched_if #(
    parameter int SYM_W         = 14,
    parameter int SYMS_PER_WORD = 8,
    parameter int MAX_IN        = 9,
    parameter int ADDR_W        = 14
);
    localparam int WORD_W = SYM_W * SYMS_PER_WORD;

    logic                      sym_valid;
    logic [3:0]                sym_cnt;
    logic [SYM_W*MAX_IN-1:0]   sym_data;
    logic                      in_ready;
    logic                      flush;
    logic                      mem_en;
    logic                      mem_we;
    logic [ADDR_W-1:0]         mem_addr;
    logic [WORD_W-1:0]         mem_wdata;
    logic [WORD_W-1:0]         mem_dout;
    logic                      rd_req;
    logic [ADDR_W-1:0]         rd_addr;
    logic                      rd_gnt;
    logic                      rd_valid;
    logic [WORD_W-1:0]         rd_data;
    logic [ADDR_W:0]           words_written;
    logic                      done;
    logic                      ovf;

    modport slave (
        input  sym_valid, sym_cnt, sym_data, flush, mem_dout, rd_req, rd_addr,
        output in_ready, mem_en, mem_we, mem_addr, mem_wdata,
               rd_gnt, rd_valid, rd_data, words_written, done, ovf
    );

    modport master (
        output sym_valid, sym_cnt, sym_data, flush, mem_dout, rd_req, rd_addr,
        input  in_ready, mem_en, mem_we, mem_addr, mem_wdata,
               rd_gnt, rd_valid, rd_data, words_written, done, ovf
    );
endinterface

// File: rtl/rle_word_sched.sv
// Packs RLE symbols into 112-bit words, writes them to the single-port output
// SRAM and shares that port with the entropy-coder reader under a starvation limit.
module rle_word_sched #(
    parameter int SYM_W         = 14,
    parameter int SYMS_PER_WORD = 8,
    parameter int MAX_IN        = 9,
    parameter int ADDR_W        = 14,
    parameter int DEPTH         = 16384,
    parameter int STARVE        = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    rle_word_sched_if.slave      bus
);
    localparam int WORD_W = SYM_W * SYMS_PER_WORD;
    // 15 symbols left after the in_ready threshold plus one full beat
    localparam int ACC_N  = 24;
    localparam int STV_W  = $clog2(STARVE + 1);

    typedef enum logic [1:0] {S_RUN, S_FLUSH, S_DONE} state_t;

    state_t              r_state, w_state_nx;
    logic [SYM_W-1:0]    r_acc [ACC_N];
    logic [SYM_W-1:0]    w_acc_nx [ACC_N];
    logic [4:0]          r_fill;
    logic [4:0]          w_fill_nx, w_drain, w_base, w_idx;
    logic [STV_W-1:0]    r_stv;
    logic [ADDR_W:0]     r_wcnt;
    logic                r_mem_en, r_mem_we, r_rd_gnt, r_rd_valid, r_ovf;
    logic [ADDR_W-1:0]   r_mem_addr;
    logic [WORD_W-1:0]   r_mem_wdata, w_word;
    logic [3:0]          w_cnt;
    logic                w_in_ready, w_done, w_accept;
    logic                w_wr_pend, w_rd_ok, w_rd_win, w_wr_win, w_full;

    always_ff @(posedge clk) begin
        if (!reset) r_state <= S_RUN;
        else        r_state <= w_state_nx;
    end

    always_comb begin
        w_state_nx = r_state;
        case (r_state)
            S_RUN:   if (bus.flush) w_state_nx = S_FLUSH;
            S_FLUSH: if (r_fill == 5'd0) w_state_nx = S_DONE;
            S_DONE:  w_state_nx = S_RUN;
            default: w_state_nx = S_RUN;
        endcase
    end

    always_comb begin
        w_in_ready = (r_state == S_RUN) && (r_fill <= 5'd15);
        w_done     = (r_state == S_DONE);
    end

    // Arbitration: writes win unless a committed read has waited STARVE cycles
    always_comb begin
        w_cnt     = (bus.sym_cnt > 4'(MAX_IN)) ? 4'(MAX_IN) : bus.sym_cnt;
        w_accept  = bus.sym_valid && w_in_ready;
        w_wr_pend = (r_fill >= 5'd8) || ((r_state == S_FLUSH) && (r_fill != 5'd0));
        w_rd_ok   = bus.rd_req && ({1'b0, bus.rd_addr} < r_wcnt);
        w_rd_win  = w_rd_ok && (!w_wr_pend || (r_stv >= STV_W'(STARVE)));
        w_wr_win  = w_wr_pend && !w_rd_win;
        w_full    = (r_wcnt == (ADDR_W+1)'(DEPTH));
        w_drain   = !w_wr_win ? 5'd0 : ((r_fill >= 5'd8) ? 5'd8 : r_fill);
        w_base    = r_fill - w_drain;
        w_fill_nx = w_base + (w_accept ? {1'b0, w_cnt} : 5'd0);
    end

    // Oldest symbols sit at index 0; a padded flush word leaves no live entries
    always_comb begin
        w_idx = '0;
        for (int i = 0; i < ACC_N; i++) w_acc_nx[i] = r_acc[i];
        if (w_wr_win) begin
            for (int i = 0; i < ACC_N - 8; i++) w_acc_nx[i] = r_acc[i + 8];
        end
        if (w_accept) begin
            for (int j = 0; j < MAX_IN; j++) begin
                w_idx = w_base + 5'(j);
                if (j < int'(w_cnt))
                    w_acc_nx[w_idx] = bus.sym_data[SYM_W*(MAX_IN-j)-1 -: SYM_W];
            end
        end
    end

    always_comb begin
        w_word = '0;
        for (int i = 0; i < SYMS_PER_WORD; i++)
            w_word[WORD_W-1-SYM_W*i -: SYM_W] = (5'(i) < r_fill) ? r_acc[i] : '0;
    end

    always_ff @(posedge clk) begin
        r_acc <= w_acc_nx;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_fill      <= '0;
            r_stv       <= '0;
            r_wcnt      <= '0;
            r_mem_en    <= 1'b0;
            r_mem_we    <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
            r_rd_gnt    <= 1'b0;
            r_rd_valid  <= 1'b0;
            r_ovf       <= 1'b0;
        end else begin
            r_fill     <= w_fill_nx;
            r_stv      <= (w_rd_ok && w_wr_win) ? r_stv + 1'b1 : '0;
            r_mem_en   <= 1'b0;
            r_mem_we   <= 1'b0;
            r_rd_gnt   <= 1'b0;
            r_rd_valid <= r_rd_gnt;
            if (w_rd_win) begin
                r_mem_en   <= 1'b1;
                r_mem_addr <= bus.rd_addr;
                r_rd_gnt   <= 1'b1;
            end else if (w_wr_win) begin
                // A full memory drops the word but still consumes the symbols
                if (w_full) begin
                    r_ovf <= 1'b1;
                end else begin
                    r_mem_en    <= 1'b1;
                    r_mem_we    <= 1'b1;
                    r_mem_addr  <= r_wcnt[ADDR_W-1:0];
                    r_mem_wdata <= w_word;
                    r_wcnt      <= r_wcnt + 1'b1;
                end
            end
        end
    end

    assign bus.in_ready      = w_in_ready;
    assign bus.done          = w_done;
    assign bus.mem_en        = r_mem_en;
    assign bus.mem_we        = r_mem_we;
    assign bus.mem_addr      = r_mem_addr;
    assign bus.mem_wdata     = r_mem_wdata;
    assign bus.rd_gnt        = r_rd_gnt;
    assign bus.rd_valid      = r_rd_valid;
    assign bus.rd_data       = bus.mem_dout;
    assign bus.words_written = r_wcnt;
    assign bus.ovf           = r_ovf;
endmodule

// File: tb/tb_rle_word_sched.sv
// Bench for rle_word_sched: a symbol-queue reference model predicts every SRAM
// word, with a behavioural SRAM answering the scheduler's reads.
module tb_rle_word_sched;
    localparam int DEPTH = 16384;

    logic clk   = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    rle_word_sched_if bus ();
    rle_word_sched dut (.clk(clk), .reset(reset), .bus(bus));

    logic [111:0] sram [DEPTH];
    always @(posedge clk) begin
        if (bus.mem_en) begin
            if (bus.mem_we) sram[bus.mem_addr] <= bus.mem_wdata;
            else            bus.mem_dout <= sram[bus.mem_addr];
        end
    end

    logic [13:0]  q [$];
    logic [111:0] exp_mem [DEPTH];
    int           n_wr;
    logic         wr_seen;
    logic [111:0] got_w, exp_w;
    logic [13:0]  got_a;
    int           exp_a;
    int           checks = 0;
    int           passes = 0;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time exceeded, got timeout want completion");
        $fatal(1, "watchdog");
    end

    // One clock: record accepted symbols, and for any SRAM write pop the word the model expects
    task automatic tick();
        logic acc;
        int n;
        logic [13:0] s [9];
        acc = bus.sym_valid && bus.in_ready;
        n = (bus.sym_cnt > 4'd9) ? 9 : int'(bus.sym_cnt);
        for (int i = 0; i < 9; i++) s[i] = bus.sym_data[125-14*i -: 14];
        @(posedge clk);
        #1;
        if (acc) for (int i = 0; i < n; i++) q.push_back(s[i]);
        wr_seen = bus.mem_en && bus.mem_we;
        if (wr_seen) begin
            exp_w = '0;
            for (int i = 0; i < 8; i++)
                if (q.size() > 0) exp_w[111-14*i -: 14] = q.pop_front();
            got_w = bus.mem_wdata;
            got_a = bus.mem_addr;
            exp_a = n_wr;
            exp_mem[n_wr % DEPTH] = exp_w;
            n_wr++;
        end
    endtask

    task automatic apply_reset();
        reset = 1'b0;
        bus.sym_valid = 1'b0; bus.sym_cnt = '0; bus.sym_data = '0;
        bus.flush = 1'b0; bus.rd_req = 1'b0; bus.rd_addr = '0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b1;
        q.delete();
        n_wr = 0;
    endtask

    task automatic drive_beat(input logic v, input logic [3:0] c);
        bus.sym_valid = v;
        bus.sym_cnt   = c;
        for (int i = 0; i < 9; i++) bus.sym_data[125-14*i -: 14] = 14'($urandom);
    endtask

    task automatic test_reset();
        apply_reset();
        checks++; if (bus.mem_en !== 1'b0 || bus.mem_we !== 1'b0)
            $display("FAIL reset_mem_ctl: en=%b we=%b want 0 0", bus.mem_en, bus.mem_we); else passes++;
        checks++; if (bus.mem_addr !== 14'd0 || bus.mem_wdata !== 112'd0)
            $display("FAIL reset_mem_bus: addr=%h wdata=%h want 0", bus.mem_addr, bus.mem_wdata); else passes++;
        checks++; if (bus.words_written !== 15'd0 || bus.ovf !== 1'b0)
            $display("FAIL reset_count: ww=%0d ovf=%b want 0 0", bus.words_written, bus.ovf); else passes++;
        checks++; if (bus.rd_gnt !== 1'b0 || bus.rd_valid !== 1'b0 || bus.done !== 1'b0)
            $display("FAIL reset_pulses: gnt=%b vld=%b done=%b want 0", bus.rd_gnt, bus.rd_valid, bus.done); else passes++;
    endtask

    task automatic test_single_row();
        logic [111:0] row;
        apply_reset();
        row = '0;
        for (int i = 0; i < 8; i++) begin
            bus.sym_valid = 1'b1;
            bus.sym_cnt   = 4'd1;
            bus.sym_data  = '0;
            bus.sym_data[125:112] = {6'd0, 8'(i + 1)};
            row[111-14*i -: 14]   = {6'd0, 8'(i + 1)};
            checks++; if (bus.in_ready !== 1'b1)
                $display("FAIL row_in_ready: got %b want 1 (beat %0d)", bus.in_ready, i); else passes++;
            tick();
            checks++; if (wr_seen !== 1'b0)
                $display("FAIL row_early_write: got write want none (beat %0d)", i); else passes++;
        end
        bus.sym_valid = 1'b0;
        tick();
        checks++; if (wr_seen !== 1'b1)
            $display("FAIL row_write: got %b want 1", wr_seen); else passes++;
        checks++; if (got_a !== 14'd0 || got_w !== row)
            $display("FAIL row_word: addr=%h data=%h want 0 %h", got_a, got_w, row); else passes++;
        checks++; if (bus.words_written !== 15'd1)
            $display("FAIL row_count: got %0d want 1", bus.words_written); else passes++;
    endtask

    task automatic test_flush();
        logic [111:0] w0, w1;
        int nw, nd;
        apply_reset();
        w0 = '0;
        w1 = 'x;
        bus.sym_valid = 1'b1;
        bus.sym_cnt   = 4'd9;
        for (int i = 0; i < 8; i++) begin
            bus.sym_data[125-14*i -: 14] = 14'($urandom);
            w0[111-14*i -: 14] = bus.sym_data[125-14*i -: 14];
        end
        bus.sym_data[13:0] = 14'h3F7F;
        tick();
        bus.sym_valid = 1'b0;
        bus.flush     = 1'b1;
        tick();
        bus.flush = 1'b0;
        checks++; if (wr_seen !== 1'b1 || got_w !== w0 || got_a !== 14'd0)
            $display("FAIL flush_word0: seen=%b addr=%h data=%h want 1 0 %h", wr_seen, got_a, got_w, w0); else passes++;
        nw = 0;
        nd = 0;
        for (int k = 0; k < 8; k++) begin
            if (nd == 0) begin
                checks++; if (bus.in_ready !== 1'b0)
                    $display("FAIL flush_in_ready: got %b want 0 (cycle %0d)", bus.in_ready, k); else passes++;
            end
            tick();
            if (wr_seen) begin nw++; w1 = got_w; end
            if (bus.done === 1'b1) nd++;
        end
        checks++; if (nw !== 1 || w1 !== {14'h3F7F, 98'd0})
            $display("FAIL flush_pad_word: writes=%0d data=%h want 1 %h", nw, w1, {14'h3F7F, 98'd0}); else passes++;
        checks++; if (nd !== 1)
            $display("FAIL flush_done: pulses=%0d want 1", nd); else passes++;
        checks++; if (bus.words_written !== 15'd2 || bus.in_ready !== 1'b1)
            $display("FAIL flush_after: ww=%0d rdy=%b want 2 1", bus.words_written, bus.in_ready); else passes++;
    endtask

    task automatic test_stream();
        apply_reset();
        for (int k = 0; k < 240; k++) begin
            logic pend;
            if (k < 120) drive_beat(1'b1, 4'd9);
            else         drive_beat(1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)));
            checks++; if (bus.in_ready !== (q.size() <= 15))
                $display("FAIL stream_in_ready: got %b want %b fill=%0d", bus.in_ready, (q.size() <= 15), q.size()); else passes++;
            pend = (q.size() >= 8);
            tick();
            checks++; if (wr_seen !== pend)
                $display("FAIL stream_write_slot: got %b want %b (cycle %0d)", wr_seen, pend, k); else passes++;
            checks++; if (q.size() > 24)
                $display("FAIL stream_fill: got %0d want <=24", q.size()); else passes++;
            if (wr_seen) begin
                checks++; if (got_w !== exp_w || got_a !== exp_a[13:0])
                    $display("FAIL stream_word: addr=%h data=%h want %h %h", got_a, got_w, exp_a[13:0], exp_w); else passes++;
            end
        end
        bus.sym_valid = 1'b0;
        checks++; if (bus.words_written !== 15'(n_wr))
            $display("FAIL stream_count: got %0d want %0d", bus.words_written, n_wr); else passes++;
    endtask

    task automatic test_read_starve();
        int waited;
        logic got;
        for (int k = 0; k < 4; k++) begin drive_beat(1'b1, 4'd9); tick(); end
        bus.rd_req  = 1'b1;
        bus.rd_addr = 14'd0;
        waited = 0;
        got = 1'b0;
        while (!got && waited < 12) begin
            drive_beat(1'b1, 4'd9);
            tick();
            waited++;
            if (bus.rd_gnt === 1'b1) got = 1'b1;
        end
        bus.rd_req = 1'b0;
        checks++; if (got !== 1'b1 || waited > 5)
            $display("FAIL starve_gnt: granted=%b after %0d cycles want grant within 5", got, waited); else passes++;
        drive_beat(1'b1, 4'd9);
        tick();
        checks++; if (bus.rd_valid !== 1'b1 || bus.rd_data !== exp_mem[0])
            $display("FAIL starve_data: vld=%b data=%h want 1 %h", bus.rd_valid, bus.rd_data, exp_mem[0]); else passes++;
        checks++; if (bus.rd_gnt !== 1'b0)
            $display("FAIL starve_gnt_pulse: got %b want 0", bus.rd_gnt); else passes++;
        bus.sym_valid = 1'b0;
    endtask

    task automatic test_uncommitted();
        int k;
        logic got;
        apply_reset();
        bus.rd_req  = 1'b1;
        bus.rd_addr = 14'd5;
        k = 0;
        got = 1'b0;
        while (!got && k < 40) begin
            int ww;
            drive_beat(1'b1, 4'd8);
            ww = int'(bus.words_written);
            tick();
            k++;
            if (bus.rd_gnt === 1'b1) begin
                got = 1'b1;
                checks++; if (ww < 6)
                    $display("FAIL uncommitted_gnt: granted with ww=%0d want ww>=6", ww); else passes++;
            end
        end
        bus.rd_req = 1'b0;
        checks++; if (got !== 1'b1)
            $display("FAIL uncommitted_timeout: granted=%b want 1", got); else passes++;
        bus.sym_valid = 1'b0;
        tick();
        checks++; if (bus.rd_valid !== 1'b1 || bus.rd_data !== exp_mem[5])
            $display("FAIL uncommitted_data: vld=%b data=%h want 1 %h", bus.rd_valid, bus.rd_data, exp_mem[5]); else passes++;
    endtask

    task automatic test_ovf_and_reset();
        int k, nen, nd, nw;
        apply_reset();
        k = 0;
        while (bus.words_written !== 15'(DEPTH) && k < 20000) begin
            drive_beat(1'b1, 4'd9);
            tick();
            k++;
        end
        checks++; if (bus.words_written !== 15'(DEPTH))
            $display("FAIL ovf_fill: ww=%0d want %0d", bus.words_written, DEPTH); else passes++;
        checks++; if (bus.ovf !== 1'b0)
            $display("FAIL ovf_early: got %b want 0", bus.ovf); else passes++;
        nen = 0;
        for (int i = 0; i < 6; i++) begin
            drive_beat(1'b1, 4'd9);
            tick();
            if (bus.mem_en === 1'b1) nen++;
        end
        checks++; if (bus.ovf !== 1'b1 || nen !== 0)
            $display("FAIL ovf_set: ovf=%b mem_en_cycles=%0d want 1 0", bus.ovf, nen); else passes++;
        checks++; if (bus.words_written !== 15'(DEPTH))
            $display("FAIL ovf_saturate: ww=%0d want %0d", bus.words_written, DEPTH); else passes++;
        bus.sym_valid = 1'b0;
        repeat (3) tick();
        checks++; if (bus.ovf !== 1'b1)
            $display("FAIL ovf_sticky: got %b want 1", bus.ovf); else passes++;
        drive_beat(1'b1, 4'd5);
        bus.flush = 1'b1;
        tick();
        bus.flush = 1'b0;
        bus.sym_valid = 1'b0;
        checks++; if (bus.in_ready !== 1'b0)
            $display("FAIL midflush_state: in_ready=%b want 0", bus.in_ready); else passes++;
        reset = 1'b0;
        @(posedge clk);
        #1;
        checks++; if (bus.mem_en !== 1'b0 || bus.mem_we !== 1'b0 || bus.mem_addr !== 14'd0 || bus.mem_wdata !== 112'd0)
            $display("FAIL midflush_mem: en=%b we=%b addr=%h wdata=%h want 0", bus.mem_en, bus.mem_we, bus.mem_addr, bus.mem_wdata); else passes++;
        checks++; if (bus.ovf !== 1'b0 || bus.words_written !== 15'd0 || bus.done !== 1'b0 || bus.rd_gnt !== 1'b0 || bus.rd_valid !== 1'b0)
            $display("FAIL midflush_ctl: ovf=%b ww=%0d done=%b gnt=%b vld=%b want 0", bus.ovf, bus.words_written, bus.done, bus.rd_gnt, bus.rd_valid); else passes++;
        reset = 1'b1;
        q.delete();
        n_wr = 0;
        nd = 0;
        nw = 0;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (bus.done === 1'b1) nd++;
            if (wr_seen) nw++;
        end
        checks++; if (nd !== 0 || nw !== 0)
            $display("FAIL midflush_abort: done=%0d writes=%0d want 0 0", nd, nw); else passes++;
    endtask

    initial begin
        test_reset();
        test_single_row();
        test_flush();
        test_stream();
        test_read_starve();
        test_uncommitted();
        test_ovf_and_reset();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
